fifo_rr_scheduler: RTL and testbench

- Moves 6-bit words from four input FIFO instances into four output FIFO instances.
- Each cycle, a round-robin arbiter picks one non-empty input FIFO and pops it.
- One cycle later the popped word is pushed into the output FIFO named by its destination field.
- Global backpressure: while any output FIFO asserts Pausa, no new pops are issued.

---
 rtl/fifo_rr_scheduler_pkg.sv | 13 +
 rtl/fifo_rr_scheduler_arb.sv | 36 +++
 rtl/fifo_rr_scheduler.sv | 101 ++++++++++
 tb/tb_fifo_rr_scheduler.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_rr_scheduler_pkg.sv
// Shared types and sizes for the FIFO round-robin schedulers.
package fifo_rr_scheduler_pkg;
    localparam int NUM_Q  = 4;
    localparam int IDX_W  = 2;
    localparam int DEST_W = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        STALL = 2'd2,
        DRAIN = 2'd3
    } state_t;
endpackage

// File: rtl/fifo_rr_scheduler_arb.sv
// Four-way round-robin arbiter: combinational grant, pointer advances past each taken grant.
module rr_arbiter_4
    import fifo_rr_scheduler_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [NUM_Q-1:0] eligible,
    input  logic             advance,
    output logic             grant_valid,
    output logic [IDX_W-1:0] grant_idx
);
    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] scan_idx;

    // scan from the far end so the candidate closest to rr_ptr is written last
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = rr_ptr;
        scan_idx    = rr_ptr;
        for (int k = NUM_Q - 1; k >= 0; k--) begin
            scan_idx = rr_ptr + IDX_W'(k);
            if (eligible[scan_idx]) begin
                grant_valid = 1'b1;
                grant_idx   = scan_idx;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr <= '0;
        end else if (advance && grant_valid) begin
            rr_ptr <= grant_idx + IDX_W'(1);
        end
    end
endmodule

// File: rtl/fifo_rr_scheduler.sv
// Pops input FIFOs round-robin and pushes each word to the output FIFO named by its dest field.
//   state | meaning
//   IDLE  | every input FIFO empty
//   ISSUE | pops permitted
//   STALL | an output FIFO is pausing; in-flight push still completes
//   DRAIN | nothing eligible, waiting for the last push to retire
module fifo_rr_scheduler
    import fifo_rr_scheduler_pkg::*;
#(
    parameter int DATA_WIDTH = 6,
    parameter int DEST_LSB   = 4,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_Q-1:0]              in_empty,
    input  logic [NUM_Q*DATA_WIDTH-1:0]   in_data,
    output logic [NUM_Q-1:0]              in_pop,
    input  logic [NUM_Q-1:0]              out_pausa,
    input  logic [NUM_Q-1:0]              out_full,
    output logic [NUM_Q-1:0]              out_push,
    output logic [DATA_WIDTH-1:0]         out_data,
    output logic                          active,
    output logic [NUM_Q*CNT_WIDTH-1:0]    fwd_count,
    output logic                          sched_error
);
    state_t            state, state_nxt;
    logic [NUM_Q-1:0]  eligible;
    logic              grant_valid;
    logic [IDX_W-1:0]  grant_idx;
    logic              pause;
    logic              pop_en;
    logic              valid_q;
    logic [IDX_W-1:0]  sel_q;
    logic [DATA_WIDTH-1:0] word;
    logic [DEST_W-1:0] dest;

    // a FIFO popped last cycle may still show a stale non-empty flag
    assign eligible = ~in_empty & ~in_pop;
    assign pause    = |out_pausa;
    assign pop_en   = (state == ISSUE) && !pause && grant_valid;
    assign word     = in_data[int'(sel_q)*DATA_WIDTH +: DATA_WIDTH];
    assign dest     = word[DEST_LSB+1:DEST_LSB];

    rr_arbiter_4 u_arb (
        .clk         (clk),
        .rst         (reset),
        .eligible    (eligible),
        .advance     (pop_en),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (!(&in_empty)) state_nxt = ISSUE;
            ISSUE: begin
                if (pause)             state_nxt = STALL;
                else if (!grant_valid) state_nxt = valid_q ? DRAIN : IDLE;
            end
            STALL:   if (!pause) state_nxt = ISSUE;
            DRAIN: begin
                if (!valid_q && (out_push == '0)) state_nxt = grant_valid ? ISSUE : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            active      <= 1'b0;
            in_pop      <= '0;
            valid_q     <= 1'b0;
            sel_q       <= '0;
            out_push    <= '0;
            out_data    <= '0;
            fwd_count   <= '0;
            sched_error <= 1'b0;
        end else begin
            state   <= state_nxt;
            active  <= (state_nxt == ISSUE) || (state_nxt == DRAIN);
            in_pop  <= pop_en ? (NUM_Q'(1) << grant_idx) : '0;
            valid_q <= pop_en;
            if (pop_en) sel_q <= grant_idx;

            if (valid_q) begin
                out_data <= word;
                out_push <= NUM_Q'(1) << dest;
                fwd_count[int'(dest)*CNT_WIDTH +: CNT_WIDTH] <=
                    fwd_count[int'(dest)*CNT_WIDTH +: CNT_WIDTH] + CNT_WIDTH'(1);
            end else begin
                out_push <= '0;
            end

            // the push lands at the end of the cycle it is presented, so judge fullness then
            sched_error <= sched_error | (|(out_push & out_full));
        end
    end
endmodule

// File: tb/tb_fifo_rr_scheduler.sv
// Bench for fifo_rr_scheduler: queue-backed input FIFOs, a word-level reference model and directed cases.
module tb_fifo_rr_scheduler;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  in_empty = 4'hF;
    logic [23:0] in_data = '0;
    logic [3:0]  in_pop;
    logic [3:0]  out_pausa = 4'h0;
    logic [3:0]  out_full = 4'h0;
    logic [3:0]  out_push;
    logic [5:0]  out_data;
    logic        active;
    logic [31:0] fwd_count;
    logic        sched_error;

    fifo_rr_scheduler #(.DATA_WIDTH(6), .DEST_LSB(4), .CNT_WIDTH(8)) dut (
        .clk(clk), .reset(reset), .in_empty(in_empty), .in_data(in_data), .in_pop(in_pop),
        .out_pausa(out_pausa), .out_full(out_full), .out_push(out_push), .out_data(out_data),
        .active(active), .fwd_count(fwd_count), .sched_error(sched_error)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    bit cmp_en = 1'b0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // input FIFOs: head word is presented, a pop seen during a cycle removes it at the next edge
    logic [5:0] q [4][$];
    bit         hide [4];
    logic [3:0] pend;

    task automatic refresh();
        for (int i = 0; i < 4; i++) begin
            in_empty[i] = (q[i].size() == 0) || hide[i];
            in_data[i*6 +: 6] = (q[i].size() > 0) ? q[i][0] : 6'd0;
        end
    endtask

    always begin
        @(negedge clk);
        pend = in_pop;
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++)
            if (pend[i] && q[i].size() > 0) void'(q[i].pop_front());
        refresh();
    end

    // reference model: words granted round-robin, each delivered one cycle after its pop
    int         m_mode = 0;       // 0 idle, 1 issue, 2 stall, 3 drain
    int         m_ptr = 0;
    int         m_inflight = -1;  // word taken by the last grant, -1 if none
    logic [3:0] m_pop = '0;
    logic [3:0] m_push = '0;
    logic [5:0] m_data = '0;
    int         m_cnt [4] = '{0, 0, 0, 0};
    bit         m_err = 1'b0;
    bit         m_active = 1'b0;

    task automatic model_step();
        int g, d, idx, nxt_mode, nxt_inflight;
        logic [3:0] nxt_pop, nxt_push;
        bit paused;
        if (reset) begin
            m_mode = 0; m_ptr = 0; m_inflight = -1; m_pop = '0; m_push = '0;
            m_data = '0; m_err = 1'b0; m_active = 1'b0;
            for (int i = 0; i < 4; i++) m_cnt[i] = 0;
            return;
        end
        g = -1;
        for (int k = 0; k < 4; k++) begin
            idx = (m_ptr + k) % 4;
            if (g < 0 && !in_empty[idx] && !m_pop[idx]) g = idx;
        end
        paused = (out_pausa != 4'h0);
        m_err = m_err || ((m_push & out_full) != 4'h0);
        nxt_push = '0;
        if (m_inflight >= 0) begin
            d = (m_inflight / 16) % 4;
            nxt_push = 4'b0001 << d;
            m_data = 6'(m_inflight);
            m_cnt[d] = (m_cnt[d] + 1) % 256;
        end
        nxt_pop = '0;
        nxt_inflight = -1;
        if (m_mode == 1 && !paused && g >= 0) begin
            nxt_pop = 4'b0001 << g;
            nxt_inflight = int'(q[g][0]);
            m_ptr = (g + 1) % 4;
        end
        nxt_mode = m_mode;
        case (m_mode)
            0: if (in_empty != 4'hF) nxt_mode = 1;
            1: if (paused) nxt_mode = 2;
               else if (g < 0) nxt_mode = (m_inflight >= 0) ? 3 : 0;
            2: if (!paused) nxt_mode = 1;
            default: if (m_inflight < 0 && m_push == 4'h0) nxt_mode = (g >= 0) ? 1 : 0;
        endcase
        m_mode = nxt_mode;
        m_pop = nxt_pop;
        m_push = nxt_push;
        m_inflight = nxt_inflight;
        m_active = (nxt_mode == 1) || (nxt_mode == 3);
    endtask

    always begin
        @(negedge clk);
        model_step();
    end

    always begin
        @(posedge clk);
        #2;
        if (cmp_en) begin
            check("m_in_pop", in_pop, m_pop);
            check("m_out_push", out_push, m_push);
            check("m_out_data", out_data, m_data);
            check("m_active", active, m_active);
            check("m_sched_error", sched_error, m_err);
            check("m_fwd_count", fwd_count,
                  {8'(m_cnt[3]), 8'(m_cnt[2]), 8'(m_cnt[1]), 8'(m_cnt[0])});
        end
    end

    // stimulus helpers
    int pops_q[$];
    int npush, first_push, last_push, cyc;

    task automatic tick();
        @(posedge clk);
        #3;
    endtask

    task automatic clear_rec();
        pops_q.delete();
        npush = 0; first_push = 0; last_push = 0; cyc = 0;
    endtask

    task automatic tick_rec();
        tick();
        cyc++;
        for (int i = 0; i < 4; i++) if (in_pop[i]) pops_q.push_back(i);
        if (out_push != 4'h0) begin
            if (npush == 0) first_push = cyc;
            last_push = cyc;
            npush++;
        end
    endtask

    task automatic wait_pop(input int bound, output bit hit);
        hit = 1'b0;
        for (int c = 0; c < bound && !hit; c++) begin
            tick();
            if (in_pop != 4'h0) hit = 1'b1;
        end
    endtask

    task automatic wait_push(input int bound, output bit hit);
        hit = 1'b0;
        for (int c = 0; c < bound && !hit; c++) begin
            tick();
            if (out_push != 4'h0) hit = 1'b1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bit hit;
        refresh();
        repeat (2) @(posedge clk);
        #3;
        reset = 1'b0;
        cmp_en = 1'b1;

        tick();
        check("reset_pop_push", {in_pop, out_push}, 8'h00);
        check("reset_data", out_data, 6'h00);
        check("reset_active_err", {active, sched_error}, 2'b00);
        check("reset_fwd", fwd_count, 32'h0);

        // single word on input 2, dest 3
        q[2].push_back(6'h35);
        refresh();
        wait_pop(8, hit);
        check("single_pop_seen", hit, 1'b1);
        check("single_pop", in_pop, 4'b0100);
        tick();
        check("single_push", out_push, 4'b1000);
        check("single_data", out_data, 6'h35);
        check("single_fwd3", fwd_count[31:24], 8'd1);
        tick();
        check("single_active_t2", active, 1'b1);
        tick();
        check("single_idle_t3", active, 1'b0);
        repeat (2) tick();

        // reset while a push is pending
        q[1].push_back(6'h05);
        refresh();
        wait_pop(8, hit);
        check("rst_pop_seen", hit, 1'b1);
        reset = 1'b1;
        for (int i = 0; i < 4; i++) q[i].delete();
        refresh();
        #1;
        check("rst_async_outs", {in_pop, out_push, out_data, active, sched_error}, 16'h0);
        check("rst_async_fwd", fwd_count, 32'h0);
        tick();
        check("rst_no_push", out_push, 4'h0);
        reset = 1'b0;
        tick();
        tick();
        check("rst_after_push", out_push, 4'h0);
        check("rst_after_fwd", fwd_count, 32'h0);

        // fairness: three words per input, destinations balanced
        clear_rec();
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 3; j++) q[i].push_back(6'(((i + j) % 4) * 16 + i * 3 + j));
        refresh();
        repeat (25) tick_rec();
        check("fair_npops", pops_q.size(), 12);
        for (int k = 0; k < pops_q.size(); k++) check("fair_order", pops_q[k], k % 4);
        check("fair_npush", npush, 12);
        check("fair_span", last_push - first_push, 11);
        check("fair_fwd", fwd_count, 32'h03030303);

        // backpressure: pause output 1 for five cycles mid-stream
        clear_rec();
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) q[i].push_back(6'(j * 16 + i * 4 + j));
        refresh();
        for (int c = 0; c < 20 && pops_q.size() < 5; c++) tick_rec();
        check("bp_reached", pops_q.size(), 5);
        out_pausa = 4'b0010;
        tick_rec();
        check("bp_inflight_push", out_push != 4'h0, 1'b1);
        check("bp_stall_pop0", in_pop, 4'h0);
        for (int c = 0; c < 4; c++) begin
            tick_rec();
            check("bp_stall_pop", in_pop, 4'h0);
        end
        out_pausa = 4'b0000;
        tick_rec();
        check("bp_reissue_pop", in_pop, 4'h0);
        tick_rec();
        check("bp_resume", in_pop != 4'h0, 1'b1);
        repeat (20) tick_rec();
        check("bp_npops", pops_q.size(), 16);
        for (int k = 0; k < pops_q.size(); k++) check("bp_order", pops_q[k], k % 4);
        check("bp_fwd", fwd_count, 32'h07070707);

        // empty flag raised late on a one-word FIFO
        clear_rec();
        hide[0] = 1'b1;
        q[0].push_back(6'h21);
        refresh();
        tick_rec();
        hide[0] = 1'b0;
        refresh();
        repeat (12) tick_rec();
        check("lag_npops", pops_q.size(), 1);
        if (pops_q.size() > 0) check("lag_pop_idx", pops_q[0], 0);
        check("lag_npush", npush, 1);
        check("lag_fwd2", fwd_count[23:16], 8'd8);

        // push into a full output FIFO
        out_full = 4'b0010;
        q[3].push_back(6'h1A);
        refresh();
        wait_push(10, hit);
        check("err_push_seen", hit, 1'b1);
        check("err_push", out_push, 4'b0010);
        check("err_not_yet", sched_error, 1'b0);
        tick();
        check("err_set", sched_error, 1'b1);
        out_full = 4'b0000;
        repeat (3) tick();
        check("err_sticky", sched_error, 1'b1);
        reset = 1'b1;
        tick();
        check("err_cleared", sched_error, 1'b0);
        reset = 1'b0;
        repeat (2) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
